// File: rtl/mdu_iter.sv
// Iterative multiply/divide unit: latency-modelled multiply, restoring divide, HI/LO state.
// Define MDU_MACC_EN to enable madd/maddu/msub/msubu on sel 4-7.
module mdu_iter #(
   parameter int unsigned WIDTH   = 32,
   parameter int unsigned MUL_LAT = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req,
   input  logic             start,
   input  logic [2:0]       sel,
   input  logic             we,
   input  logic             hi_sel,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             busy,
   output logic [WIDTH-1:0] C
);

   localparam int unsigned MaxLat = (MUL_LAT > WIDTH) ? MUL_LAT : WIDTH;
   localparam int unsigned CntW   = $clog2(MaxLat + 1);
   localparam logic [CntW-1:0] MulInit = CntW'(MUL_LAT - 1);
   localparam logic [CntW-1:0] DivInit = CntW'(WIDTH - 1);
   localparam logic [CntW-1:0] CntOne  = CntW'(1);

   typedef enum logic [1:0] {StIdle, StMul, StDiv, StFix} state_e;

   state_e             state_q;
   logic [CntW-1:0]    cnt_q;
   logic [WIDTH-1:0]   hi_q, lo_q;
   logic [2*WIDTH-1:0] prod_q;
   logic [WIDTH-1:0]   quo_q, rem_q, dvs_q, dvd_q;
   logic               q_neg_q, r_neg_q, dvz_q;
`ifdef MDU_MACC_EN
   logic               acc_q, sub_q;
`endif

   logic               op_sgn, is_div, is_mul, a_neg, b_neg;
   logic [WIDTH-1:0]   a_abs, b_abs;
   logic [2*WIDTH-1:0] a_ext, b_ext, prod, mul_res;
   logic [WIDTH:0]     shl, diff;
   logic               fits;
   logic [WIDTH-1:0]   q_fin, r_fin;

   assign op_sgn = ~sel[0];
   assign is_div = (sel[2:1] == 2'b01);
`ifdef MDU_MACC_EN
   assign is_mul = ~is_div;
`else
   assign is_mul = (sel[2:1] == 2'b00);
`endif

   // Sign-extended operands give the correct low 2*WIDTH bits for both signednesses.
   assign a_ext = {{WIDTH{op_sgn & A[WIDTH-1]}}, A};
   assign b_ext = {{WIDTH{op_sgn & B[WIDTH-1]}}, B};
   assign prod  = a_ext * b_ext;

   assign a_neg = op_sgn & A[WIDTH-1];
   assign b_neg = op_sgn & B[WIDTH-1];
   assign a_abs = a_neg ? -A : A;
   assign b_abs = b_neg ? -B : B;

   // Remainder stays below divisor, so the trial difference fits in WIDTH+1 bits with a valid sign.
   assign shl  = {rem_q, quo_q[WIDTH-1]};
   assign diff = shl - {1'b0, dvs_q};
   assign fits = ~diff[WIDTH];

   assign q_fin = q_neg_q ? -quo_q : quo_q;
   assign r_fin = r_neg_q ? -rem_q : rem_q;

`ifdef MDU_MACC_EN
   always_comb begin
      mul_res = prod_q;
      if (acc_q) begin
         mul_res = sub_q ? ({hi_q, lo_q} - prod_q) : ({hi_q, lo_q} + prod_q);
      end
   end
`else
   assign mul_res = prod_q;
`endif

   assign busy = (state_q != StIdle);
   assign C    = hi_sel ? hi_q : lo_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         prod_q  <= '0;
         quo_q   <= '0;
         rem_q   <= '0;
         dvs_q   <= '0;
         dvd_q   <= '0;
         q_neg_q <= 1'b0;
         r_neg_q <= 1'b0;
         dvz_q   <= 1'b0;
`ifdef MDU_MACC_EN
         acc_q   <= 1'b0;
         sub_q   <= 1'b0;
`endif
      end else begin
         case (state_q)
            StIdle: begin
               if (!req) begin
                  if (start) begin
                     if (is_div) begin
                        state_q <= StDiv;
                        cnt_q   <= DivInit;
                        quo_q   <= a_abs;
                        rem_q   <= '0;
                        dvs_q   <= b_abs;
                        dvd_q   <= A;
                        q_neg_q <= a_neg ^ b_neg;
                        r_neg_q <= a_neg;
                        dvz_q   <= (B == '0);
                     end else if (is_mul) begin
                        state_q <= StMul;
                        cnt_q   <= MulInit;
                        prod_q  <= prod;
`ifdef MDU_MACC_EN
                        acc_q   <= sel[2];
                        sub_q   <= sel[1];
`endif
                     end
                  end else if (we) begin
                     if (hi_sel) hi_q <= A;
                     else        lo_q <= A;
                  end
               end
            end
            StMul: begin
               if (req) begin
                  state_q <= StIdle;
                  cnt_q   <= '0;
               end else if (cnt_q == '0) begin
                  {hi_q, lo_q} <= mul_res;
                  state_q      <= StIdle;
               end else begin
                  cnt_q <= cnt_q - CntOne;
               end
            end
            StDiv: begin
               if (req) begin
                  state_q <= StIdle;
                  cnt_q   <= '0;
               end else begin
                  rem_q <= fits ? diff[WIDTH-1:0] : shl[WIDTH-1:0];
                  quo_q <= {quo_q[WIDTH-2:0], fits};
                  if (cnt_q == '0) state_q <= StFix;
                  else             cnt_q   <= cnt_q - CntOne;
               end
            end
            StFix: begin
               if (!req) begin
                  if (dvz_q) begin
                     lo_q <= '1;
                     hi_q <= dvd_q;
                  end else begin
                     lo_q <= q_fin;
                     hi_q <= r_fin;
                  end
               end
               state_q <= StIdle;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule
